// File: rtl/cc_pkg.sv
// Shared types, default widths and helpers for the core-to-cache arbiter.
package cc_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned MAX_CORES      = 8;
  localparam int unsigned CORE_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // One-hot vector for a core index; callers truncate to their core count.
  function automatic logic [MAX_CORES-1:0] onehot(input logic [CORE_IDX_W-1:0] idx);
    logic [MAX_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cc_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_winner, wrapping.
module cc_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_winner_i,
  output logic [$clog2(N_REQ)-1:0] winner_o,
  output logic                     valid_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  // Scan offsets 1..N from the previous winner; the nearest requester wins.
  always_comb begin : p_pick
    int unsigned cand;
    cand     = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_winner_i) + off) % N_REQ;
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cc_multi_core_arb.sv
// N-core to single cache port arbiter: round-robin, bounded lock bursts, access timeout.
module cc_multi_core_arb
  import cc_pkg::*;
#(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CORES-1:0]             core_hreq,
  input  logic [N_CORES-1:0]             core_hlock,
  input  logic [N_CORES-1:0]             core_hwrite,
  input  logic [N_CORES-1:0][ADDR_W-1:0] core_haddr,
  input  logic [N_CORES-1:0][DATA_W-1:0] core_hwdata,
  output logic [N_CORES-1:0]             core_hgrant,
  output logic [N_CORES-1:0]             core_hready,
  output logic                           core_herror,
  output logic [DATA_W-1:0]              core_hrdata,
  output logic                           mem_req,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_ack,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int unsigned IDX_W = $clog2(N_CORES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    last_winner_q, last_winner_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [TO_W-1:0]     timeout_cnt_q, timeout_cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [N_CORES-1:0]  hready_q, hready_d;
  logic                herror_q, herror_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_CORES-1:0]  grant_c;
  logic [IDX_W-1:0]    arb_winner;
  logic                arb_valid;
  logic                in_access_c;

  cc_rr_arbiter #(.N_REQ(N_CORES)) u_rr (
    .req_i         (core_hreq),
    .last_winner_i (last_winner_q),
    .winner_o      (arb_winner),
    .valid_o       (arb_valid)
  );

  // Grant and cache-side signals decode straight from registered state.
  assign in_access_c = (state_q == ACCESS);
  assign grant_c     = (state_q == ACCESS || state_q == RESP)
                       ? N_CORES'(onehot(CORE_IDX_W'(winner_q))) : '0;
  assign core_hgrant = grant_c;
  assign mem_req     = in_access_c;
  assign mem_write   = in_access_c & write_q;
  assign mem_addr    = in_access_c ? addr_q  : '0;
  assign mem_wdata   = in_access_c ? wdata_q : '0;
  assign core_hready = hready_q;
  assign core_herror = herror_q;
  assign core_hrdata = rdata_q;

  // State register and latched transaction, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      winner_q      <= '0;
      last_winner_q <= IDX_W'(N_CORES - 1);
      burst_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      hready_q      <= '0;
      herror_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      hready_q      <= hready_d;
      herror_q      <= herror_d;
      rdata_q       <= rdata_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack or timeout, then respond or chain a locked access.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    timeout_cnt_d = '0;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    hready_d      = '0;
    herror_d      = 1'b0;
    rdata_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          winner_d    = arb_winner;
          write_d     = core_hwrite[arb_winner];
          addr_d      = core_haddr[arb_winner];
          wdata_d     = core_hwdata[arb_winner];
          burst_cnt_d = BC_W'(1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d  = RESP;
          hready_d = grant_c;
          rdata_d  = write_q ? '0 : mem_rdata;
        end else if (timeout_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d  = RESP;
          hready_d = grant_c;
          herror_d = 1'b1;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        if (core_hlock[winner_q] && core_hreq[winner_q] &&
            (burst_cnt_q < BC_W'(MAX_BURST))) begin
          write_d     = core_hwrite[winner_q];
          addr_d      = core_haddr[winner_q];
          wdata_d     = core_hwdata[winner_q];
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          state_d     = ACCESS;
        end else begin
          last_winner_d = winner_q;
          burst_cnt_d   = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cc_multi_core_arb.md
Name: cc_multi_core_arb

Overview:
- Next-generation core-to-cache access block: N cores, each running the hreq/hgrant/hready protocol, share one cache-side port.
- Parametrised data/address width.
- Round-robin arbitration with a bounded lock (burst) mode.
- Per-access timeout with error response.
- Sits between the core clusters and the cache controller.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, address width; matches the `ADDR_BUS_WIDTH define.
- DATA_W, 8, data width (8 = legacy byte bus).
- TIMEOUT, 64, maximum ACCESS cycles before an error response (>=2).
- MAX_BURST, 4, maximum consecutive locked grants to one core (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- core_hreq  in  N_CORES  per-core request; held until hready.
- core_hlock  in  N_CORES  per-core request to keep the grant after the current access.
- core_hwrite  in  N_CORES  1 = write, 0 = read.
- core_haddr  in  N_CORES x ADDR_W  per-core address.
- core_hwdata  in  N_CORES x DATA_W  per-core write data.
- core_hgrant  out  N_CORES  one-hot grant; zero when idle.
- core_hready  out  N_CORES  one-cycle completion pulse to the granted core.
- core_herror  out  1  valid with hready; 1 = timeout.
- core_hrdata  out  DATA_W  read data, shared; valid with hready.
- mem_req  out  1  cache-side request.
- mem_write  out  1  cache-side write enable.
- mem_addr  out  ADDR_W  cache-side address.
- mem_wdata  out  DATA_W  cache-side write data.
- mem_ack  in  1  cache-side completion; sampled only in ACCESS.
- mem_rdata  in  DATA_W  valid when mem_ack=1.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_winner=N_CORES-1 (core 0 wins first); burst_cnt=0; timeout_cnt=0. A reset mid-access aborts it: no hready is issued, and mem_req drops on the next cycle.
- States:
  - IDLE:
    - If any core_hreq=1, the winner is the first requesting core searching from last_winner+1, wrapping modulo N_CORES.
    - Latch the winner's hwrite/haddr/hwdata; go to ACCESS; burst_cnt=1.
  - ACCESS:
    - core_hgrant[w]=1.
    - mem_req=1, with mem_* driven from latched registers; mem_* are stable for the whole state.
    - timeout_cnt increments each cycle.
    - mem_ack=1: latch mem_rdata (reads only; writes latch 0); go to RESP; herror=0.
    - timeout_cnt reaches TIMEOUT-1 with no ack: go to RESP with herror=1, rdata=0.
    - If ack and timeout coincide, ack wins.
  - RESP:
    - core_hready[w]=1 for exactly this cycle; core_herror and core_hrdata valid.
    - core_hgrant[w] stays 1; mem_req=0; timeout_cnt cleared.
    - If hlock[w]=1, hreq[w]=1 and burst_cnt<MAX_BURST: latch the new request from core w, burst_cnt++, go to ACCESS (no re-arbitration).
    - Otherwise: last_winner=w, go to IDLE.
- Core contract: a core may present its next request in the same cycle it sees hready.
- Minimum latency: hreq sampled at cycle T, ACCESS at T+1, mem_ack at T+1, hready at T+2.
- Locked back-to-back access: one RESP cycle between ACCESS phases; no idle gap.
- mem_ack in IDLE/RESP is ignored.
- Outputs are registered except the core_hgrant/mem_* decode from registered state.
- Any core dropping hreq while granted: the access still completes; hready is still pulsed.
- Fairness: with all cores requesting and no lock, grants rotate 0,1,2,...,N-1,0.

Decomposition:
- Package cc_pkg holds:
  - arb_state_e {IDLE, ACCESS, RESP}.
  - Default width constants (ADDR_W, DATA_W).
  - Function onehot(idx).
- Sub-module cc_rr_arbiter: purely combinational; inputs req[N], last_winner; outputs winner index and valid. Reused by future multi-bank blocks.

Test Plan:
- Single read: core 2 reads 0x00A5, mem_ack one cycle later with rdata=0x3C -> hgrant[2] from T+1, mem_addr=0x00A5, hready[2] at T+2, hrdata=0x3C, herror=0.
- Round-robin: all 4 cores request writes continuously, no lock, immediate acks -> grant order 0,1,2,3,0,1; each mem_addr/mem_wdata matches the granted core's inputs.
- Burst: core 1 holds hlock=1 with 6 queued writes, MAX_BURST=4, core 3 also requesting -> core 1 granted 4 times consecutively, then core 3, then core 1 resumes.
- Timeout: mem_ack held 0 for core 0 read, TIMEOUT=64 -> hready[0] with herror=1, hrdata=0 64 cycles after ACCESS entry; a stray mem_ack the following cycle is ignored.
- Ack/timeout collision: mem_ack=1 on the final TIMEOUT cycle with rdata=0x5A -> herror=0, hrdata=0x5A.
- Reset mid-ACCESS: assert rst for 1 cycle during core 2's access -> next cycle all grants/hready/mem_req=0; the next arbitration selects core 0 first.
